// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM memory port arbiter.
//   WAIT_W       width of the ISSUE wait-state counter
//   arb_state_e  arbiter FSM states (IDLE -> ISSUE -> RESP -> IDLE)
//   arb_owner_e  which pipeline stage owns the latched transaction
package mem_port_arbiter_pkg;

   localparam int WAIT_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge bus to the unified single-ported memory.
//   req    held high by the master until ack
//   we     1 = write, 0 = read
//   addr   word-aligned byte address
//   wdata  write data
//   ack    memory done; rdata valid in the same cycle
//   rdata  read data
// master: the arbiter side; slave: the memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait-state timer for the arbiter's ISSUE phase.
//   clk, reset  clock and synchronous active-low reset
//   start       clears the count (asserted on entry to ISSUE)
//   en          counts one wait state per cycle
//   expired     count has reached MAX_WAIT-1
// The count cannot wrap: the arbiter leaves ISSUE as soon as expired is seen.
module mem_port_arbiter_wait_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic en,
   output logic expired
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and the data
// stage (DM). DM has strict priority. A granted request is latched, issued on
// the req/ack bus until ack or timeout, then the owner gets a one-cycle ready
// pulse with registered read data.
//   clk, reset            clock, synchronous active-low reset
//   if_req/if_addr        fetch read request, held until if_ready
//   if_rdata/if_ready     fetched word and its completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request, held until dm_ready
//   dm_rdata/dm_ready     load data (0 for stores) and its completion pulse
//   mem                   master side of the memory req/ack bus
//   stall_f/stall_m       per-stage stall to the hazard logic
//   bus_error             sticky timeout flag, cleared only by reset
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ready,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ready,
   mem_port_arbiter_if.master  mem,
   output logic                stall_f,
   output logic                stall_m,
   output logic                bus_error
);

   // Masking keeps every address bit in use while forcing word alignment.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   arb_state_e        state_q, state_d;
   arb_owner_e        owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              bus_error_q, bus_error_d;
   logic              timer_start;
   logic              timer_en;
   logic              timer_expired;

   mem_port_arbiter_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (timer_start),
      .en      (timer_en),
      .expired (timer_expired)
   );

   assign timer_en = (state_q == ARB_ISSUE) && !mem.ack;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      bus_error_d = bus_error_q;
      timer_start = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            // DM is the older instruction, so it always wins a tie.
            if (dm_req) begin
               owner_d     = OWNER_DM;
               we_d        = dm_we;
               addr_d      = dm_addr & ALIGN_MASK;
               wdata_d     = dm_wdata;
               timer_start = 1'b1;
               state_d     = ARB_ISSUE;
            end else if (if_req) begin
               owner_d     = OWNER_IF;
               we_d        = 1'b0;
               addr_d      = if_addr & ALIGN_MASK;
               wdata_d     = '0;
               timer_start = 1'b1;
               state_d     = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            // An ack in the final allowed cycle still counts as success.
            if (mem.ack) begin
               rdata_d = we_q ? '0 : mem.rdata;
               state_d = ARB_RESP;
            end else if (timer_expired) begin
               rdata_d     = '0;
               bus_error_d = 1'b1;
               state_d     = ARB_RESP;
            end
         end
         ARB_RESP: begin
            // Requests are not sampled here; the owner drops req on this edge.
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWNER_IF;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign mem.req   = (state_q == ARB_ISSUE);
   assign mem.we    = we_q;
   assign mem.addr  = addr_q;
   assign mem.wdata = wdata_q;

   assign if_ready  = (state_q == ARB_RESP) && (owner_q == OWNER_IF);
   assign dm_ready  = (state_q == ARB_RESP) && (owner_q == OWNER_DM);
   assign if_rdata  = rdata_q;
   assign dm_rdata  = rdata_q;

   assign stall_f   = if_req && !if_ready;
   assign stall_m   = dm_req && !dm_ready;
   assign bus_error = bus_error_q;

endmodule
